// File: rtl/ham_pkg.sv
// ham_pkg: constants, FSM state type and helpers shared by the Hamming(7,4)
// nibble packer and its FIFO.
//   CW_W / NIB_W       codeword and nibble widths
//   D*_IDX             codeword bit positions that carry data (d4,d3,d2,d1)
//   state_t            packer FSM state (EMPTY / HALF)
//   extract_nib()      strips the parity bits from a codeword
//   syndrome_flag()    1 when a codeword has a nonzero syndrome
package ham_pkg;

    localparam int CW_W  = 7;
    localparam int NIB_W = 4;

    // Codeword bit i is Hamming position i+1, so the data bits sit at the
    // non-power-of-two positions 7,6,5,3 -> indices 6,5,4,2.
    localparam int D4_IDX = 6;
    localparam int D3_IDX = 5;
    localparam int D2_IDX = 4;
    localparam int D1_IDX = 2;

    typedef enum logic {
        EMPTY = 1'b0,   // no nibble held
        HALF  = 1'b1    // one nibble held, waiting for its partner
    } state_t;

    function automatic logic [NIB_W-1:0] extract_nib(input logic [CW_W-1:0] cw);
        return {cw[D4_IDX], cw[D3_IDX], cw[D2_IDX], cw[D1_IDX]};
    endfunction

    function automatic logic syndrome_flag(input logic [CW_W-1:0] cw);
        logic s1, s2, s4;
        s1 = cw[0] ^ cw[2] ^ cw[4] ^ cw[6];
        s2 = cw[1] ^ cw[2] ^ cw[5] ^ cw[6];
        s4 = cw[3] ^ cw[4] ^ cw[5] ^ cw[6];
        return |{s4, s2, s1};
    endfunction

endpackage

// File: rtl/ham_byte_fifo.sv
// ham_byte_fifo: circular-buffer FIFO with an unregistered read port.
//   clk, rst          clock, asynchronous active-high reset
//   wr_en, wr_data    push one entry (caller never pushes while full)
//   rd_en             pop the head; ignored while empty
//   rd_data           head entry, read straight from the array at rd_ptr
//   full, empty       status flags derived from level
//   level             number of stored entries (0..DEPTH)
// Pointers carry one extra bit so full and empty are distinguishable; they
// wrap modulo 2*DEPTH.
module ham_byte_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 9
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [W-1:0]             wr_data,
    input  logic                     rd_en,
    output logic [W-1:0]             rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_L = (AW + 1)'(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         do_rd;

    assign level   = wr_ptr - rd_ptr;
    assign full    = (level == DEPTH_L);
    assign empty   = (level == '0);
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem[rd_ptr[AW-1:0]];

    // NOTE: the array is reset because the head is visible on the output
    // without a register stage and must read as zero after reset; this is
    // affordable only because DEPTH is small.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (wr_en) begin
                mem[wr_ptr[AW-1:0]] <= wr_data;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/hamming_nibble_packer.sv
// hamming_nibble_packer: strips parity from corrected Hamming(7,4) codewords,
// pairs the nibbles into bytes and queues them behind a valid/ready port.
//   clk, rst                 clock, asynchronous active-high reset
//   cw_in, cw_valid, cw_ready  codeword input handshake
//   flush                    pulse: close a half-filled byte with a zero nibble
//   byte_out, byte_err       FIFO head byte and its syndrome flag
//   byte_valid, byte_ready   byte output handshake
//   level                    bytes currently buffered
// Parameters: DEPTH (FIFO entries, power of two >= 2), MSN_FIRST (1: first
// nibble lands in byte[7:4]).
// Build option: define HAM_SYNDROME_CHK_EN to recompute each codeword's
// syndrome and flag bytes built from a nonzero-syndrome codeword; otherwise
// byte_err is tied low and no flag is stored.
module hamming_nibble_packer
    import ham_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter bit MSN_FIRST = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [6:0]               cw_in,
    input  logic                     cw_valid,
    output logic                     cw_ready,
    input  logic                     flush,
    output logic [7:0]               byte_out,
    output logic                     byte_err,
    output logic                     byte_valid,
    input  logic                     byte_ready,
    output logic [$clog2(DEPTH):0]   level
);

    state_t           state;
    state_t           state_next;
    logic [NIB_W-1:0] nib;
    logic [NIB_W-1:0] hold;
    logic             flush_pend;
    logic             accept;
    logic             pair_wr;
    logic             pad_wr;
    logic             wr_en;
    logic [7:0]       wr_byte;
    logic             full;
    logic             empty;

    assign nib        = extract_nib(cw_in);
    assign byte_valid = !empty;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= EMPTY;
        else     state <= state_next;
    end

    // Next-state logic: a byte leaves HALF either by pairing or by padding.
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        unique case (state)
            EMPTY: if (accept)           state_next = HALF;
            HALF:  if (accept || pad_wr) state_next = EMPTY;
        endcase
    end

    // Outputs. A pending flush blocks input until the padded byte is written;
    // otherwise only a completing accept needs a free FIFO slot. cw_ready
    // never looks at byte_ready, keeping the two ports decoupled.
    always_comb begin
        cw_ready = !flush_pend && ((state == EMPTY) || !full);
        accept   = cw_valid && cw_ready;
        pair_wr  = accept && (state == HALF);
        pad_wr   = flush_pend && !full;
        wr_en    = pair_wr || pad_wr;
        if (pair_wr) wr_byte = MSN_FIRST ? {hold, nib} : {nib, hold};
        else         wr_byte = MSN_FIRST ? {hold, 4'h0} : {4'h0, hold};
    end

    // Hold register and flush request. A flush alongside a completing accept
    // is redundant; alongside a first-nibble accept it applies to that nibble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold       <= '0;
            flush_pend <= 1'b0;
        end else begin
            if (accept && (state == EMPTY)) hold <= nib;
            if (pad_wr) begin
                flush_pend <= 1'b0;
            end else if (flush && (((state == HALF) && !accept) ||
                                   ((state == EMPTY) && accept))) begin
                flush_pend <= 1'b1;
            end
        end
    end

`ifdef HAM_SYNDROME_CHK_EN
    logic       nib_err;
    logic       hold_err;
    logic       wr_err;
    logic [8:0] rd_entry;

    assign nib_err = syndrome_flag(cw_in);
    // A padded nibble contributes no error, so only the held flag survives.
    assign wr_err  = pair_wr ? (hold_err | nib_err) : hold_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                             hold_err <= 1'b0;
        else if (accept && (state == EMPTY)) hold_err <= nib_err;
    end

    ham_byte_fifo #(.DEPTH(DEPTH), .W(9)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_data ({wr_err, wr_byte}),
        .rd_en   (byte_ready),
        .rd_data (rd_entry),
        .full    (full),
        .empty   (empty),
        .level   (level)
    );

    assign byte_out = rd_entry[7:0];
    assign byte_err = rd_entry[8];
`else
    // Parity bits are only needed by the syndrome check.
    logic unused_parity;
    assign unused_parity = ^{cw_in[3], cw_in[1], cw_in[0]};

    ham_byte_fifo #(.DEPTH(DEPTH), .W(8)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_data (wr_byte),
        .rd_en   (byte_ready),
        .rd_data (byte_out),
        .full    (full),
        .empty   (empty),
        .level   (level)
    );

    assign byte_err = 1'b0;
`endif

endmodule

// File: tb/tb_hamming_nibble_packer.sv
// tb_hamming_nibble_packer: directed self-checking bench for
// hamming_nibble_packer with DEPTH=4, MSN_FIRST=1.
module tb_hamming_nibble_packer;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] cw_in;
    logic       cw_valid;
    logic       cw_ready;
    logic       flush;
    logic [7:0] byte_out;
    logic       byte_err;
    logic       byte_valid;
    logic       byte_ready;
    logic [2:0] level;

    int checks = 0;
    int errors = 0;

`ifdef HAM_SYNDROME_CHK_EN
    localparam logic EXP_SYN_ERR = 1'b1;
`else
    localparam logic EXP_SYN_ERR = 1'b0;
`endif

    hamming_nibble_packer #(.DEPTH(4), .MSN_FIRST(1'b1)) dut (
        .clk        (clk),
        .rst        (rst),
        .cw_in      (cw_in),
        .cw_valid   (cw_valid),
        .cw_ready   (cw_ready),
        .flush      (flush),
        .byte_out   (byte_out),
        .byte_err   (byte_err),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .level      (level)
    );

    always #5 clk = ~clk;

    // Valid Hamming(7,4) codeword for nibble {d4,d3,d2,d1}.
    function automatic logic [6:0] enc(input logic [3:0] n);
        logic p1, p2, p4;
        p1 = n[0] ^ n[1] ^ n[3];
        p2 = n[0] ^ n[2] ^ n[3];
        p4 = n[1] ^ n[2] ^ n[3];
        return {n[3], n[2], n[1], p4, n[0], p2, p1};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Present one codeword for one edge; it must be accepted.
    task automatic send(input logic [6:0] cw, input string name);
        cw_in    = cw;
        cw_valid = 1'b1;
        checks++;
        if (cw_ready !== 1'b1) begin
            $display("FAIL %s cw_ready: got %b expected 1", name, cw_ready);
            errors++;
        end
        tick();
        cw_valid = 1'b0;
    endtask

    // Expect a byte at the head, then pop it.
    task automatic pop_expect(input logic [7:0] exp, input string name);
        checks++;
        if (byte_valid !== 1'b1 || byte_out !== exp) begin
            $display("FAIL %s head: got valid=%b byte=%h expected valid=1 byte=%h",
                     name, byte_valid, byte_out, exp);
            errors++;
        end
        byte_ready = 1'b1;
        tick();
        byte_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; cw_in = '0; cw_valid = 0; flush = 0; byte_ready = 0;
        #12;
        checks++;
        if (byte_valid !== 1'b0 || level !== 3'd0 || byte_out !== 8'h00 ||
            byte_err !== 1'b0 || cw_ready !== 1'b1) begin
            $display("FAIL reset_state: got valid=%b level=%0d byte=%h err=%b ready=%b expected 0 0 00 0 1",
                     byte_valid, level, byte_out, byte_err, cw_ready);
            errors++;
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic;
        send(7'b1010010, "basic_first");
        checks++;
        if (byte_valid !== 1'b0) begin
            $display("FAIL basic_half_valid: got %b expected 0", byte_valid);
            errors++;
        end
        send(7'b0101101, "basic_second");
        checks++;
        if (byte_valid !== 1'b1 || byte_out !== 8'hA5 || byte_err !== 1'b0 || level !== 3'd1) begin
            $display("FAIL basic_byte: got valid=%b byte=%h err=%b level=%0d expected 1 a5 0 1",
                     byte_valid, byte_out, byte_err, level);
            errors++;
        end
        pop_expect(8'hA5, "basic_pop");
        checks++;
        if (level !== 3'd0) begin
            $display("FAIL basic_drained: got level=%0d expected 0", level);
            errors++;
        end
    endtask

    // 12 codewords streamed with the consumer stalled for 16 cycles; a small
    // scoreboard predicts cw_ready, byte_valid and the head every cycle.
    task automatic test_back_to_back;
        logic [7:0] q[$];
        logic [3:0] m_hold = '0;
        bit         m_half = 0;
        int         idx = 0;
        int         max_level = 0;
        bit         exp_ready, do_rd, do_acc;
        int         cyc = 0;
        while (!(idx == 12 && q.size() == 0) && cyc < 80) begin
            cw_valid   = (idx < 12);
            cw_in      = enc(4'(idx + 1));
            byte_ready = (cyc >= 16);
            #0;
            exp_ready = !m_half || (q.size() < 4);
            checks++;
            if (cw_ready !== exp_ready) begin
                $display("FAIL b2b_cw_ready cyc %0d: got %b expected %b", cyc, cw_ready, exp_ready);
                errors++;
            end
            checks++;
            if (byte_valid !== (q.size() > 0) ||
                (q.size() > 0 && byte_out !== q[0]) || level !== 3'(q.size())) begin
                $display("FAIL b2b_head cyc %0d: got valid=%b byte=%h level=%0d expected level=%0d byte=%h",
                         cyc, byte_valid, byte_out, level, q.size(), (q.size() > 0) ? q[0] : 8'h00);
                errors++;
            end
            do_rd  = byte_ready && (q.size() > 0);
            do_acc = cw_valid && exp_ready;
            if (do_rd) void'(q.pop_front());
            if (do_acc) begin
                if (m_half) begin q.push_back({m_hold, 4'(idx + 1)}); m_half = 0; end
                else begin m_hold = 4'(idx + 1); m_half = 1; end
                idx++;
            end
            if (q.size() > max_level) max_level = q.size();
            tick();
            cyc++;
        end
        cw_valid = 0; byte_ready = 0;
        checks++;
        if (cyc >= 80 || max_level != 4) begin
            $display("FAIL b2b_complete: got cycles=%0d max_level=%0d expected <80 and 4", cyc, max_level);
            errors++;
        end
    endtask

    task automatic test_flush;
        // Flush with nothing held must be ignored.
        flush = 1'b1; tick(); flush = 1'b0; tick(); tick();
        checks++;
        if (byte_valid !== 1'b0 || level !== 3'd0) begin
            $display("FAIL flush_empty_ignored: got valid=%b level=%0d expected 0 0", byte_valid, level);
            errors++;
        end
        for (int i = 0; i < 4; i++) begin
            send(enc(4'(2 * i + 1)), "flush_fill");
            send(enc(4'(2 * i + 2)), "flush_fill");
        end
        send(7'b1010010, "flush_held");
        checks++;
        if (cw_ready !== 1'b0 || level !== 3'd4) begin
            $display("FAIL flush_full_half: got ready=%b level=%0d expected 0 4", cw_ready, level);
            errors++;
        end
        flush = 1'b1; tick(); flush = 1'b0;
        tick(); tick();
        checks++;
        if (cw_ready !== 1'b0 || level !== 3'd4) begin
            $display("FAIL flush_pending: got ready=%b level=%0d expected 0 4", cw_ready, level);
            errors++;
        end
        pop_expect(8'h12, "flush_free_slot");
        checks++;
        if (cw_ready !== 1'b0 || level !== 3'd3) begin
            $display("FAIL flush_after_free: got ready=%b level=%0d expected 0 3", cw_ready, level);
            errors++;
        end
        tick();
        checks++;
        if (cw_ready !== 1'b1 || level !== 3'd4) begin
            $display("FAIL flush_written: got ready=%b level=%0d expected 1 4", cw_ready, level);
            errors++;
        end
        pop_expect(8'h34, "flush_drain");
        pop_expect(8'h56, "flush_drain");
        pop_expect(8'h78, "flush_drain");
        pop_expect(8'hA0, "flush_padded");
        tick(); tick();
        checks++;
        if (byte_valid !== 1'b0 || level !== 3'd0) begin
            $display("FAIL flush_single_pad: got valid=%b level=%0d expected 0 0", byte_valid, level);
            errors++;
        end
    endtask

    task automatic test_syndrome;
        send(7'b1010011, "syn_first");
        send(7'b0101101, "syn_second");
        checks++;
        if (byte_out !== 8'hA5 || byte_err !== EXP_SYN_ERR) begin
            $display("FAIL syndrome_flag: got byte=%h err=%b expected a5 %b", byte_out, byte_err, EXP_SYN_ERR);
            errors++;
        end
        pop_expect(8'hA5, "syn_pop");
        // The flag must not leak into the next clean byte.
        send(7'b1010010, "syn_clean1");
        send(7'b0101101, "syn_clean2");
        checks++;
        if (byte_err !== 1'b0) begin
            $display("FAIL syndrome_clean: got err=%b expected 0", byte_err);
            errors++;
        end
        pop_expect(8'hA5, "syn_clean_pop");
    endtask

    task automatic test_wrap;
        logic [7:0] q[$];
        logic [3:0] a, b;
        send(enc(4'h1), "wrap_fill"); send(enc(4'h2), "wrap_fill");
        send(enc(4'h3), "wrap_fill"); send(enc(4'h4), "wrap_fill");
        q.push_back(8'h12); q.push_back(8'h34);
        for (int k = 0; k < 6; k++) begin
            a = 4'(2 * k + 5);
            b = 4'(2 * k + 6);
            send(enc(a), "wrap_first");
            cw_in = enc(b); cw_valid = 1'b1; byte_ready = 1'b1;
            tick();
            cw_valid = 1'b0; byte_ready = 1'b0;
            void'(q.pop_front());
            q.push_back({a, b});
            checks++;
            if (level !== 3'd2 || byte_out !== q[0]) begin
                $display("FAIL wrap_rw k=%0d: got level=%0d byte=%h expected 2 %h", k, level, byte_out, q[0]);
                errors++;
            end
        end
        pop_expect(q[0], "wrap_drain");
        pop_expect(q[1], "wrap_drain");
    endtask

    task automatic test_reset_mid;
        for (int i = 0; i < 3; i++) begin
            send(enc(4'(i)), "rmid_fill"); send(enc(4'(i + 8)), "rmid_fill");
        end
        send(enc(4'hF), "rmid_half");
        checks++;
        if (level !== 3'd3) begin
            $display("FAIL rmid_level_before: got %0d expected 3", level);
            errors++;
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (byte_valid !== 1'b0 || level !== 3'd0 || cw_ready !== 1'b1) begin
            $display("FAIL rmid_async: got valid=%b level=%0d ready=%b expected 0 0 1", byte_valid, level, cw_ready);
            errors++;
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
        send(enc(4'h6), "rmid_new1");
        send(enc(4'h9), "rmid_new2");
        checks++;
        if (level !== 3'd1 || byte_out !== 8'h69) begin
            $display("FAIL rmid_fresh_byte: got level=%0d byte=%h expected 1 69", level, byte_out);
            errors++;
        end
        pop_expect(8'h69, "rmid_pop");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_flush();
        test_syndrome();
        test_wrap();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Safety net in case a handshake never completes.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/hamming_nibble_packer.md
# hamming_nibble_packer

Downstream stage of the Hamming(7,4) error detection/correction block. It accepts corrected 7-bit codewords and strips the parity bits to recover 4-bit nibbles. It pairs consecutive nibbles into bytes and buffers them in a small FIFO behind a valid/ready output. It terminates the codeword path and hands byte data to the consumer logic.

## Interface
- DEPTH, 4, number of byte entries in the output FIFO; must be a power of two and at least 2
- MSN_FIRST, 1, 1: first nibble of a pair is byte[7:4]; 0: first nibble is byte[3:0]
- clk  input  1  single clock; all state changes on the rising edge
- rst  input  1  asynchronous, active-high reset
- cw_in  input  7  corrected codeword; bit i is Hamming position i+1, so {d4,d3,d2,p4,d1,p2,p1} = cw_in[6:0]
- cw_valid  input  1  cw_in holds a codeword this cycle
- cw_ready  output  1  block accepts cw_in this cycle
- flush  input  1  one-cycle pulse that closes a half-filled byte
- byte_out  output  8  FIFO head byte
- byte_err  output  1  FIFO head byte contains a nibble whose codeword had a nonzero syndrome
- byte_valid  output  1  FIFO is not empty
- byte_ready  input  1  consumer takes the head this cycle
- level  output  $clog2(DEPTH)+1  number of bytes currently stored

## Operation
- Nibble extraction: nib = {cw_in[6], cw_in[5], cw_in[4], cw_in[2]}. This is purely combinational.
- A codeword is accepted on an edge where cw_valid && cw_ready.
- The FSM has two states:
  - EMPTY (no held nibble). An accept stores nib in the hold register and moves to HALF.
  - HALF (one nibble held). An accept writes the assembled byte into the FIFO and moves to EMPTY.
- Byte assembly: MSN_FIRST=1 gives {hold, nib}; MSN_FIRST=0 gives {nib, hold}.
- cw_ready = (state==EMPTY) || !full. It never depends on byte_ready, so there is no combinational path from byte_ready to cw_ready.
- Flush:
  - A flush pulse in HALF sets flush_pend.
  - While flush_pend is set and the FIFO is not full, the block writes the held nibble with 4'h0 in the other half and moves to EMPTY.
  - While flush_pend is set, cw_ready = 0.
  - Flush in EMPTY with flush_pend clear is ignored.
  - Flush on the same edge as an accept in HALF is ignored, because the accept completes the byte.
  - Flush on the same edge as an accept in EMPTY sets flush_pend after the nibble is stored.
- FIFO:
  - Circular buffer with wr_ptr and rd_ptr of $clog2(DEPTH)+1 bits each. Pointers wrap modulo 2*DEPTH.
  - full = (level==DEPTH), empty = (level==0).
  - A read occurs when byte_valid && byte_ready.
  - A write and a read on the same edge are both honoured when not empty; level is unchanged.
  - A write is never attempted when full.
  - byte_ready while empty has no effect.
- The error flag of each entry is the OR of the per-nibble syndrome flags of both nibbles that form it. A padded nibble contributes 0.

## Timing
- Reset (async assert, release synchronous to clk) forces:
  - state=EMPTY, hold=0, flush_pend=0
  - pointers 0, level=0
  - byte_valid=0, byte_out=8'h00, byte_err=0
  - cw_ready=1
- Latency: when the second codeword is accepted at edge N into an empty FIFO, byte_valid=1 with the byte on byte_out from just after edge N.
- byte_out and byte_err come straight from the storage array at rd_ptr, with no extra register stage. They are held stable while byte_valid && !byte_ready.
- Maximum throughput is one codeword per cycle, which gives one byte every two cycles.
- Asserting rst mid-pair drops the held nibble and all buffered bytes immediately.

## Configuration
- Macro: HAM_SYNDROME_CHK_EN.
- Defined: the block recomputes the syndrome of each accepted codeword.
  - s1 = cw[0]^cw[2]^cw[4]^cw[6]
  - s2 = cw[1]^cw[2]^cw[5]^cw[6]
  - s4 = cw[3]^cw[4]^cw[5]^cw[6]
  - The nibble flag = |{s4,s2,s1}. The flag is stored per FIFO entry and drives byte_err.
- Undefined: no syndrome logic and no flag storage; byte_err is tied to 0.

## Structure
- Shared package ham_pkg holds:
  - CW_W=7, NIB_W=4
  - the data-bit index constants {6,5,4,2}
  - the FSM state typedef (EMPTY, HALF)
- One sub-module, ham_byte_fifo, holds the storage array, pointers and level (parameter DEPTH, 9-bit entry = {err, byte}).
- The top level holds the FSM, the hold register, flush handling and the syndrome check.

## Test plan
- Reset, then accept 7'b1010010 followed by 7'b0101101 -> byte_out=8'hA5, byte_valid=1 one edge after the second accept, byte_err=0, level=1.
- Send 6 valid pairs back-to-back with byte_ready=0 and DEPTH=4 -> level saturates at 4. cw_ready drops only while in HALF. After byte_ready=1, the bytes drain in order with no loss or duplication.
- Accept 7'b1010010, then pulse flush while full, then free one entry -> exactly one byte 8'hA0 is written after the slot frees. cw_ready=0 in between.
- With HAM_SYNDROME_CHK_EN defined, accept 7'b1010011 followed by 7'b0101101 -> byte_out=8'hA5 (nibble bits are unchanged), byte_err=1. Without the macro, byte_err=0.
- Simultaneous read and write at level=2 -> level stays 2 and the head advances correctly across pointer wrap.
- Assert rst while in HALF with 3 bytes stored -> byte_valid=0, level=0 and cw_ready=1 immediately. The next two codewords form a fresh byte.
